// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one uart_transmitter among N byte requesters.
// The transmitter reports neither busy nor done, so this block counts the frame time itself.
module uart_tx_arbiter #(
    parameter int N            = 4,
    parameter int FRAME_CYCLES = 160
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*8-1:0]       req_data,
    output logic [N-1:0]         ack,
    output logic [$clog2(N)-1:0] grant_id,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    output logic                 busy
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(FRAME_CYCLES);

    typedef enum logic [1:0] {IDLE, GRANT, START, WAIT} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    ack_q, ack_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tx_start_q, tx_start_d;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    int              idx;

    // Search from ptr upward, wrapping at N, for the first pending request.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            cand = IW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        tx_start_d = tx_start_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    ack_d[pick] = 1'b1;
                    for (int k = 0; k < N; k++) begin
                        if (IW'(k) == pick) tx_data_d = req_data[8*k +: 8];
                    end
                    grant_id_d = pick;
                    ptr_d      = (pick == IW'(N-1)) ? '0 : pick + IW'(1);
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                tx_start_d = 1'b0;
                cnt_d      = CW'(FRAME_CYCLES-1);
                state_d    = START;
            end
            START: begin
                tx_start_d = 1'b1;
                cnt_d      = cnt_q - CW'(1);
                state_d    = WAIT;
            end
            WAIT: begin
                // The start cycle already consumed one count, so START+WAIT is one full frame.
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ack_q      <= '0;
            tx_data_q  <= 8'h00;
            grant_id_q <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            tx_start_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
        end
    end

    assign ack      = ack_q;
    assign grant_id = grant_id_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: a cycle-indexed transaction model predicts grants and start pulses;
// a negedge monitor pops those predictions whenever the DUT shows an ack or a start pulse.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int FC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*8-1:0] req_data;
    logic [N-1:0]  ack;
    logic [1:0]    grant_id;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          busy;

    uart_tx_arbiter #(.N(N), .FRAME_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack), .grant_id(grant_id), .tx_data(tx_data),
        .tx_start(tx_start), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         cyc;
    } ack_exp_t;

    ack_exp_t   ackq[$];
    int         startq[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;

    int         m_t, m_win, m_j, m_ptr, m_free, m_last;
    logic [31:0] m_lanes;
    ack_exp_t   m_exp, mon_e;
    int         mon_s;
    logic [7:0] exp_data;
    int         exp_gid;
    logic       exp_busy;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic rst_v, input logic [N-1:0] rq, input logic [31:0] d);
        @(negedge clk);
        rst      = rst_v;
        req      = rq;
        req_data = d;
    endtask

    // Reference model: a grant may happen once the previous frame's window has closed;
    // each grant implies an ack one cycle later and a start pulse two cycles later.
    initial begin
        m_ptr = 0; m_free = 0; m_last = -100; exp_data = 8'h00; exp_gid = 0;
        forever begin
            @(posedge clk);
            m_t = cyc;
            if (!rst) begin
                ackq.delete();
                startq.delete();
                m_ptr = 0; m_free = m_t + 1; m_last = -100;
                exp_data = 8'h00; exp_gid = 0;
            end else if (m_t >= m_free && req != '0) begin
                m_win = -1;
                for (int k = 0; k < N; k++) begin
                    m_j = (m_ptr + k) % N;
                    if (m_win < 0 && req[m_j[1:0]]) m_win = m_j;
                end
                m_lanes    = req_data >> (8 * m_win);
                m_exp.idx  = m_win;
                m_exp.data = m_lanes[7:0];
                m_exp.cyc  = m_t + 1;
                ackq.push_back(m_exp);
                startq.push_back(m_t + 2);
                m_free   = m_t + FC + 2;
                m_last   = m_t;
                m_ptr    = (m_win + 1) % N;
                exp_data = m_lanes[7:0];
                exp_gid  = m_win;
            end
            cyc = m_t + 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                if (ack != '0) begin
                    if (ackq.size() == 0) begin
                        check_output("unexpected_ack", 32'(ack), 32'h0);
                    end else begin
                        mon_e = ackq.pop_front();
                        check_output("ack_onehot", 32'(ack), 32'(1) << mon_e.idx);
                        check_output("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
                        check_output("ack_tx_data", 32'(tx_data), 32'(mon_e.data));
                        check_output("ack_grant_id", 32'(grant_id), 32'(mon_e.idx));
                    end
                end else if (ackq.size() > 0 && ackq[0].cyc <= cyc) begin
                    mon_e = ackq.pop_front();
                    check_output("missing_ack", 32'(ack), 32'(1) << mon_e.idx);
                end
                if (tx_start == 1'b0) begin
                    if (startq.size() == 0) begin
                        check_output("unexpected_start", 32'(tx_start), 32'h1);
                    end else begin
                        mon_s = startq.pop_front();
                        check_output("start_cycle", 32'(cyc), 32'(mon_s));
                    end
                end else if (startq.size() > 0 && startq[0] <= cyc) begin
                    mon_s = startq.pop_front();
                    check_output("missing_start", 32'(tx_start), 32'h0);
                end
                exp_busy = (cyc >= m_last + 1) && (cyc < m_free);
                check_output("busy", 32'(busy), 32'(exp_busy));
                check_output("tx_data_hold", 32'(tx_data), 32'(exp_data));
                check_output("grant_id_hold", 32'(grant_id), 32'(exp_gid));
            end
        end
    end

    logic [N-1:0] r_req;
    logic [31:0]  r_data;
    logic         r_rst;

    initial begin
        rst = 1'b0;
        req = 4'hF;
        req_data = 32'h44332211;
        repeat (3) begin
            @(negedge clk);
            check_output("rst_ack", 32'(ack), 32'h0);
            check_output("rst_tx_start", 32'(tx_start), 32'h1);
            check_output("rst_busy", 32'(busy), 32'h0);
            check_output("rst_tx_data", 32'(tx_data), 32'h0);
            check_output("rst_grant_id", 32'(grant_id), 32'h0);
        end
        rst = 1'b1;

        // All four lanes held: rotation 0,1,2,3,0 with starts ten cycles apart.
        repeat (50) apply_stimulus(1'b1, 4'hF, 32'h44332211);
        repeat (12) apply_stimulus(1'b1, 4'h0, 32'h0);

        apply_stimulus(1'b1, 4'b0100, 32'h00A50000);
        repeat (12) apply_stimulus(1'b1, 4'h0, 32'h0);

        // req1 raised while req0's frame is still running.
        apply_stimulus(1'b1, 4'b0001, 32'h0000005A);
        repeat (4) apply_stimulus(1'b1, 4'h0, 32'h0);
        repeat (10) apply_stimulus(1'b1, 4'b0010, 32'h00003C00);
        repeat (12) apply_stimulus(1'b1, 4'h0, 32'h0);

        // Reset lands in the third WAIT cycle of req2's frame.
        apply_stimulus(1'b1, 4'b0100, 32'h00770000);
        repeat (4) apply_stimulus(1'b1, 4'h0, 32'h0);
        apply_stimulus(1'b0, 4'h0, 32'h0);
        repeat (12) apply_stimulus(1'b1, 4'b0101, 32'h00990088);
        repeat (12) apply_stimulus(1'b1, 4'h0, 32'h0);

        // One-cycle req3 pulse while busy must be ignored.
        apply_stimulus(1'b1, 4'b0001, 32'h000000E1);
        repeat (3) apply_stimulus(1'b1, 4'h0, 32'h0);
        apply_stimulus(1'b1, 4'b1000, 32'hF0000000);
        repeat (12) apply_stimulus(1'b1, 4'h0, 32'h0);

        r_req = '0;
        r_data = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!r_req[i] && ($urandom % 4 == 0)) begin
                    r_req[i] = 1'b1;
                    r_data[8*i +: 8] = 8'($urandom);
                end else if (r_req[i] && ($urandom % 16 == 0)) begin
                    r_req[i] = 1'b0;
                end
            end
            r_rst = ($urandom % 300 != 0);
            apply_stimulus(r_rst, r_req, r_data);
        end
        repeat (15) apply_stimulus(1'b1, 4'h0, 32'h0);

        check_output("ack_queue_drained", 32'(ackq.size()), 32'h0);
        check_output("start_queue_drained", 32'(startq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
